// File: rtl/ps2_pkg.sv
// Shared PS/2 scancode constants, hex-key lookup and receiver state type.
package ps2_pkg;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;
  localparam logic [7:0] KEY_BKSP   = 8'h66;
  localparam logic [7:0] KEY_ENTER  = 8'h5A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } rx_state_t;

  // Returns {hit, nibble}; hit is 0 for anything that is not a hex key.
  function automatic logic [4:0] scan_to_hex(input logic [7:0] sc);
    logic [4:0] r;
    case (sc)
      8'h45: r = {1'b1, 4'h0};
      8'h16: r = {1'b1, 4'h1};
      8'h1E: r = {1'b1, 4'h2};
      8'h26: r = {1'b1, 4'h3};
      8'h25: r = {1'b1, 4'h4};
      8'h2E: r = {1'b1, 4'h5};
      8'h36: r = {1'b1, 4'h6};
      8'h3D: r = {1'b1, 4'h7};
      8'h3E: r = {1'b1, 4'h8};
      8'h46: r = {1'b1, 4'h9};
      8'h1C: r = {1'b1, 4'hA};
      8'h32: r = {1'b1, 4'hB};
      8'h21: r = {1'b1, 4'hC};
      8'h23: r = {1'b1, 4'hD};
      8'h24: r = {1'b1, 4'hE};
      8'h2B: r = {1'b1, 4'hF};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver running entirely on clk: synchronise, filter the PS/2 clock,
// shift in 11-bit frames and validate start/parity/stop with an in-frame timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       keysig_clk,
  input  logic       keysig_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   filt;
  logic [FW-1:0]          fcnt;
  logic                   tick;
  logic                   tick_data;

  rx_state_t   state;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        parity_bit;
  logic        stop_bit;
  logic [TW-1:0] timer;

  logic clk_s;
  logic data_s;
  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // The filtered clock flips after FILTER_LEN consecutive differing samples;
  // a 1->0 flip is a tick and captures the data line at the same moment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      filt      <= 1'b1;
      fcnt      <= '0;
      tick      <= 1'b0;
      tick_data <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], keysig_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], keysig_data};
      tick      <= 1'b0;
      if (clk_s != filt) begin
        if (fcnt == FW'(FILTER_LEN - 1)) begin
          filt      <= clk_s;
          fcnt      <= '0;
          tick      <= filt;
          tick_data <= data_s;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      stop_bit   <= 1'b0;
      timer      <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (tick || state != RECV) timer <= '0;
      else                       timer <= timer + 1'b1;
      case (state)
        IDLE: begin
          if (tick) begin
            if (!tick_data) begin
              state   <= RECV;
              bit_cnt <= 4'd1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        RECV: begin
          if (tick) begin
            if (bit_cnt <= 4'd8)       shreg <= {tick_data, shreg[7:1]};
            else if (bit_cnt == 4'd9)  parity_bit <= tick_data;
            else begin
              stop_bit <= tick_data;
              state    <= CHECK;
            end
            bit_cnt <= bit_cnt + 4'd1;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            bit_cnt   <= '0;
          end
        end
        CHECK: begin
          // Odd parity over data+parity, and the stop bit must be high.
          if ((^{shreg, parity_bit}) && stop_bit) begin
            code       <= shreg;
            code_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
          state   <= IDLE;
          bit_cnt <= '0;
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ps2_hex_entry.sv
// PS/2 hex keypad entry: frame receiver plus prefix tracking, scancode decode and
// a shift-register digit buffer with backspace, enter and clear.
module ps2_hex_entry
  import ps2_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    KEYSIG_CLK,
  input  logic                    KEYSIG_DATA,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   valid_mask,
  output logic [7:0]              code,
  output logic                    code_valid,
  output logic                    key_event,
  output logic                    commit,
  output logic                    frame_err
);

  logic       ext_flag;
  logic       brk_flag;
  logic [4:0] hex;

  ps2_frame_rx #(
    .SYNC_STAGES    (SYNC_STAGES),
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .keysig_clk  (KEYSIG_CLK),
    .keysig_data (KEYSIG_DATA),
    .code        (code),
    .code_valid  (code_valid),
    .frame_err   (frame_err)
  );

  assign hex = scan_to_hex(code);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits     <= '0;
      valid_mask <= '0;
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
      key_event  <= 1'b0;
      commit     <= 1'b0;
    end else begin
      key_event <= 1'b0;
      commit    <= 1'b0;
      if (code_valid) begin
        if (code == PREFIX_EXT) begin
          ext_flag <= 1'b1;
        end else if (code == PREFIX_BRK) begin
          brk_flag <= 1'b1;
        end else begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
          // Bytes following a prefix (break codes, extended keys) never touch the buffer.
          if (!ext_flag && !brk_flag) begin
            if (hex[4]) begin
              digits     <= {digits[4*NUM_DIGITS-5:0], hex[3:0]};
              valid_mask <= {valid_mask[NUM_DIGITS-2:0], 1'b1};
              key_event  <= !clear;
            end else if (code == KEY_BKSP && valid_mask != '0) begin
              digits     <= {4'h0, digits[4*NUM_DIGITS-1:4]};
              valid_mask <= valid_mask >> 1;
            end else if (code == KEY_ENTER) begin
              commit <= 1'b1;
            end
          end
        end
      end
      if (clear) begin
        digits     <= '0;
        valid_mask <= '0;
      end
    end
  end

endmodule
